// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package int_pkg;

   localparam int unsigned INT_NSRC = 8;
   localparam int unsigned INT_IDW  = 3;

   // Register indices on the bus window
   localparam logic [1:0] INT_ENABLE  = 2'd0;
   localparam logic [1:0] INT_MODE    = 2'd1;
   localparam logic [1:0] INT_PENDING = 2'd2;
   localparam logic [1:0] INT_CLAIM   = 2'd3;

   typedef enum logic {
      INT_IDLE   = 1'b0,
      INT_ACTIVE = 1'b1
   } int_state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus between the BUS decoder (master) and the interrupt controller (slave).
interface int_ctrl_if #(
   parameter int unsigned DW = 16
) ();
   logic          sel;
   logic          we;
   logic [1:0]    addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (output sel, output we, output addr, output wdata, input rdata);
   modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the candidate vector.
module int_prio_enc
   import int_pkg::*;
#(
   parameter int unsigned NSRC = INT_NSRC
) (
   input  logic [NSRC-1:0]    req,
   output logic               valid,
   output logic [INT_IDW-1:0] id
);

   // Scan high to low so the lowest set index is the last one written
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = INT_IDW'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: collects raw sources, presents one registered one-hot
// request to the CPU and holds it until software writes CLAIM (EOI).
module int_ctrl
   import int_pkg::*;
#(
   parameter int unsigned NSRC = INT_NSRC,
   parameter int unsigned DW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   int_ctrl_if.slave       bus,
   input  logic [NSRC-1:0] irq_src,
   output logic [NSRC-1:0] int_req
);

   logic [NSRC-1:0]    src_q, enable_q, mode_q, pend_q, pend_d;
   logic [NSRC-1:0]    pending, cand, w1c, eoi_clr, edge_det;
   logic [NSRC-1:0]    int_req_q, int_req_d;
   logic [INT_IDW-1:0] id_q, id_d, enc_id;
   logic               enc_valid, wr, eoi;
   int_state_e         state_q, state_d;

   assign wr       = bus.sel & bus.we;
   assign eoi      = wr && (bus.addr == INT_CLAIM) && (state_q == INT_ACTIVE);
   assign w1c      = (wr && bus.addr == INT_PENDING) ? bus.wdata[NSRC-1:0] : '0;
   assign eoi_clr  = eoi ? (mode_q & (NSRC'(1) << id_q)) : '0;
   assign edge_det = irq_src & ~src_q;

   // Edge bits: a new edge beats any clear in the same cycle. Level bits are
   // kept at 0 in pend_q so a later switch to edge mode starts clean.
   assign pend_d  = mode_q & ((pend_q & ~w1c & ~eoi_clr) | edge_det);
   assign pending = (mode_q & pend_q) | (~mode_q & src_q);
   assign cand    = pending & enable_q;

   // Source sampling and software-visible registers
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q    <= '0;
         pend_q   <= '0;
         enable_q <= '0;
         mode_q   <= '0;
      end else begin
         src_q  <= irq_src;
         pend_q <= pend_d;
         if (wr && bus.addr == INT_ENABLE) enable_q <= bus.wdata[NSRC-1:0];
         if (wr && bus.addr == INT_MODE)   mode_q   <= bus.wdata[NSRC-1:0];
      end
   end

   int_prio_enc #(
      .NSRC (NSRC)
   ) u_prio_enc (
      .req   (cand),
      .valid (enc_valid),
      .id    (enc_id)
   );

   // FSM state, latched id and registered request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INT_IDLE;
         id_q      <= '0;
         int_req_q <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         int_req_q <= int_req_d;
      end
   end

   // Next-state: grab the highest-priority candidate, then hold until EOI
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      int_req_d = int_req_q;
      case (state_q)
         INT_IDLE: begin
            if (enc_valid) begin
               id_d      = enc_id;
               int_req_d = NSRC'(1) << enc_id;
               state_d   = INT_ACTIVE;
            end
         end
         INT_ACTIVE: begin
            if (eoi) begin
               int_req_d = '0;
               state_d   = INT_IDLE;
            end
         end
         default: state_d = INT_IDLE;
      endcase
   end

   assign int_req = int_req_q;

   // Register read mux; bus reads 0 when not selected
   always_comb begin
      bus.rdata = '0;
      if (bus.sel) begin
         case (bus.addr)
            INT_ENABLE:  bus.rdata = DW'(enable_q);
            INT_MODE:    bus.rdata = DW'(mode_q);
            INT_PENDING: bus.rdata = DW'(pending);
            INT_CLAIM:   bus.rdata = DW'({state_q == INT_ACTIVE, 4'b0000, id_q});
            default:     bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: per-cycle vector table plus corner-case sequences.
module tb_int_ctrl;
   import int_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_src;
   logic [7:0] int_req;
   int         errors = 0;
   int         checks = 0;

   int_ctrl_if #(.DW(16)) bus ();

   int_ctrl #(
      .NSRC (8),
      .DW   (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .irq_src (irq_src),
      .int_req (int_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  src;
      logic [15:0] exp_rd;
      logic [7:0]  exp_req;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
      tick();
      bus.sel = 1'b0; bus.we = 1'b0; bus.wdata = '0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
      bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1;
      chk(name, 32'(bus.rdata), 32'(exp));
      bus.sel = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1);
   end

   initial begin
      // sel we addr wdata src exp_rd exp_req
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 2'd1, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[2]  = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[3]  = '{1'b1, 1'b0, 2'd3, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[4]  = '{1'b1, 1'b1, 2'd0, 16'h0001, 8'h00, 16'h0000, 8'h00};
      vecs[5]  = '{1'b1, 1'b1, 2'd1, 16'h0001, 8'h00, 16'h0000, 8'h00};
      vecs[6]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 16'h0001, 8'h00};
      vecs[7]  = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h01, 16'h0000, 8'h00}; // edge at N
      vecs[8]  = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h00, 16'h0001, 8'h00}; // pending at N+1
      vecs[9]  = '{1'b1, 1'b0, 2'd3, 16'h0000, 8'h00, 16'h0080, 8'h01}; // req at N+2
      vecs[10] = '{1'b1, 1'b1, 2'd3, 16'h0000, 8'h00, 16'h0080, 8'h01}; // EOI
      vecs[11] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[12] = '{1'b1, 1'b0, 2'd3, 16'h0000, 8'h00, 16'h0000, 8'h00};
      vecs[13] = '{1'b1, 1'b1, 2'd1, 16'h0000, 8'h00, 16'h0001, 8'h00}; // level mode
      vecs[14] = '{1'b1, 1'b1, 2'd0, 16'h0006, 8'h00, 16'h0001, 8'h00};
      vecs[15] = '{1'b1, 1'b0, 2'd0, 16'h0000, 8'h06, 16'h0006, 8'h00};
      vecs[16] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h06, 16'h0006, 8'h00};
      vecs[17] = '{1'b1, 1'b0, 2'd3, 16'h0000, 8'h06, 16'h0081, 8'h02};
      vecs[18] = '{1'b1, 1'b1, 2'd3, 16'h0000, 8'h06, 16'h0081, 8'h02}; // EOI, src held
      vecs[19] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h06, 16'h0006, 8'h00};
      vecs[20] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h04, 16'h0006, 8'h02}; // re-asserted
      vecs[21] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h04, 16'h0004, 8'h02};
      vecs[22] = '{1'b1, 1'b1, 2'd3, 16'h0000, 8'h04, 16'h0081, 8'h02}; // EOI
      vecs[23] = '{1'b1, 1'b0, 2'd2, 16'h0000, 8'h04, 16'h0004, 8'h00};
      vecs[24] = '{1'b1, 1'b0, 2'd3, 16'h0000, 8'h04, 16'h0082, 8'h04};
      vecs[25] = '{1'b0, 1'b0, 2'd0, 16'h0000, 8'h04, 16'h0000, 8'h04}; // sel=0 reads 0

      rst = 1'b1;
      irq_src = '0;
      bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         bus.sel   = vecs[i].sel;
         bus.we    = vecs[i].we;
         bus.addr  = vecs[i].addr;
         bus.wdata = vecs[i].wdata;
         irq_src   = vecs[i].src;
         #1;
         chk($sformatf("row%0d rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rd));
         chk($sformatf("row%0d int_req", i), 32'(int_req), 32'(vecs[i].exp_req));
         tick();
      end
      bus.sel = 1'b0; bus.we = 1'b0;

      // No preemption: edge source 0 arrives while id 2 is being served
      bus_wr(INT_ENABLE, 16'h0007);
      bus_wr(INT_MODE, 16'h0001);
      irq_src = 8'h05;
      tick();
      irq_src = 8'h04;
      chk("no preempt", 32'(int_req), 32'h04);
      rd_chk("pend edge+level", INT_PENDING, 16'h0005);
      bus_wr(INT_PENDING, 16'h0004);
      rd_chk("w1c level ignored", INT_PENDING, 16'h0005);
      irq_src = 8'h00;
      tick();
      chk("withdrawn held", 32'(int_req), 32'h04);
      rd_chk("pend after drop", INT_PENDING, 16'h0001);
      bus_wr(INT_CLAIM, 16'h0000);
      chk("eoi clears req", 32'(int_req), 32'h00);
      tick();
      chk("next req after eoi", 32'(int_req), 32'h01);
      rd_chk("claim id0", INT_CLAIM, 16'h0080);
      bus_wr(INT_CLAIM, 16'h0000);
      tick();
      chk("idle after eoi", 32'(int_req), 32'h00);
      rd_chk("edge pend cleared", INT_PENDING, 16'h0000);

      // Edge source 3 disabled: W1C alone, then edge + W1C together
      bus_wr(INT_MODE, 16'h0009);
      bus_wr(INT_ENABLE, 16'h0000);
      irq_src = 8'h08;
      tick();
      irq_src = 8'h00;
      rd_chk("pend bit3", INT_PENDING, 16'h0008);
      bus_wr(INT_PENDING, 16'h0008);
      rd_chk("w1c clears", INT_PENDING, 16'h0000);
      irq_src = 8'h08;
      bus.sel = 1'b1; bus.we = 1'b1; bus.addr = INT_PENDING; bus.wdata = 16'h0008;
      tick();
      bus.sel = 1'b0; bus.we = 1'b0; bus.wdata = '0;
      irq_src = 8'h00;
      rd_chk("set beats w1c", INT_PENDING, 16'h0008);
      bus_wr(INT_CLAIM, 16'h0000);
      chk("eoi idle req", 32'(int_req), 32'h00);
      rd_chk("eoi idle claim", INT_CLAIM, 16'h0000);
      rd_chk("eoi idle pend", INT_PENDING, 16'h0008);

      // Serve id 3, then reset in the middle of ACTIVE
      bus_wr(INT_ENABLE, 16'h0008);
      tick();
      chk("req id3", 32'(int_req), 32'h08);
      rd_chk("claim id3", INT_CLAIM, 16'h0083);
      rst = 1'b1;
      tick();
      chk("rst clears req", 32'(int_req), 32'h00);
      rst = 1'b0;
      rd_chk("rst enable", INT_ENABLE, 16'h0000);
      rd_chk("rst mode", INT_MODE, 16'h0000);
      rd_chk("rst pending", INT_PENDING, 16'h0000);
      rd_chk("rst claim", INT_CLAIM, 16'h0000);
      tick();
      chk("req stays 0", 32'(int_req), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
